// File: rtl/scu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : scu_pkg                                                        |
// | Shared types, default SCU array geometry and address-width constants     |
// | for the SCU tile sequencer.                                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package scu_pkg;

    // Default SCU array geometry.
    localparam int unsigned SCU_POF       = 4;
    localparam int unsigned SCU_PIF       = 12;
    localparam int unsigned SCU_IDX_WIDTH = 16;

    // Address width for n locations. The width is at least 1, so a
    // degenerate 1-row or 1-column array still gets a legal port.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Address widths for the default geometry.
    localparam int unsigned ROW_W = addr_w(SCU_POF);
    localparam int unsigned COL_W = addr_w(SCU_PIF);
    localparam int unsigned LIN_W = addr_w(SCU_POF * SCU_PIF);

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } scu_state_e;

endpackage
`default_nettype wire

// File: rtl/scu_ceil_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : scu_ceil_div                                                   |
// | Restoring divider by a constant DIVISOR. It develops one quotient bit    |
// | per cycle over WIDTH cycles and returns ceil(dividend / DIVISOR).        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module scu_ceil_div #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIVISOR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] dividend,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned         c_CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]      c_DIVISOR = (WIDTH + 1)'(DIVISOR);
    localparam logic [c_CNT_W-1:0]  c_LAST    = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;

    // The dividend shifts out of the top of r_quo while quotient bits
    // shift in at the bottom.
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_trial >= c_DIVISOR);

    // Iterate one restoring step per cycle. done pulses after the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_busy <= 1'b0;
            end else if (start) begin
                r_rem  <= '0;
                r_quo  <= dividend;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? WIDTH'(w_trial - c_DIVISOR) : w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt + c_CNT_ONE;
                if (r_cnt == c_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // A non-zero remainder rounds the floor quotient up. The result cannot
    // overflow because ceil(a/b) <= a for b >= 1.
    assign quotient = r_quo + WIDTH'(|r_rem);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/scu_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : scu_tile_sequencer                                             |
// | Streams every (out_idx, in_idx) work item of a dense or depthwise job    |
// | with its SCU row/col/linear address over a valid/ready interface. The    |
// | channel bands are computed once per job by two serial ceil dividers.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module scu_tile_sequencer
    import scu_pkg::*;
#(
    parameter int unsigned POF       = SCU_POF,
    parameter int unsigned PIF       = SCU_PIF,
    parameter int unsigned IDX_WIDTH = SCU_IDX_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode_dw,
    input  logic [IDX_WIDTH-1:0]          out_ch,
    input  logic [IDX_WIDTH-1:0]          in_ch,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [IDX_WIDTH-1:0]          m_out_idx,
    output logic [IDX_WIDTH-1:0]          m_in_idx,
    output logic [addr_w(POF)-1:0]        m_row,
    output logic [addr_w(PIF)-1:0]        m_col,
    output logic [addr_w(POF*PIF)-1:0]    m_linear,
    output logic                          m_last
);

    localparam int unsigned c_ROW_W = addr_w(POF);
    localparam int unsigned c_COL_W = addr_w(PIF);
    localparam int unsigned c_LIN_W = addr_w(POF * PIF);

    localparam logic [IDX_WIDTH-1:0] c_ONE     = IDX_WIDTH'(1);
    localparam logic [c_ROW_W-1:0]   c_ROW_MAX = c_ROW_W'(POF - 1);
    localparam logic [c_COL_W-1:0]   c_COL_MAX = c_COL_W'(PIF - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_ONE = c_ROW_W'(1);
    localparam logic [c_COL_W-1:0]   c_COL_ONE = c_COL_W'(1);

    scu_state_e           r_state;
    scu_state_e           w_state_nxt;
    logic                 r_mode_dw;
    logic [IDX_WIDTH-1:0] r_out_lim;
    logic [IDX_WIDTH-1:0] r_in_lim;
    logic [IDX_WIDTH-1:0] r_opr;
    logic [IDX_WIDTH-1:0] r_ipc;
    logic [IDX_WIDTH-1:0] r_out_idx;
    logic [IDX_WIDTH-1:0] r_in_idx;
    logic [IDX_WIDTH-1:0] r_o_sub;
    logic [IDX_WIDTH-1:0] r_i_sub;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   r_col;

    logic                 w_accept;
    logic                 w_fire;
    logic                 w_in_wrap;
    logic                 w_is_last;
    logic                 w_empty;
    logic                 w_div_done;
    logic                 w_div_o_done;
    logic                 w_div_i_done;
    logic [IDX_WIDTH-1:0] w_opr;
    logic [IDX_WIDTH-1:0] w_ipc;

    // abort wins over a same-cycle start. start outside IDLE is dropped.
    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_fire     = (r_state == RUN) && m_ready;
    assign w_in_wrap  = (r_in_idx == r_in_lim - c_ONE);
    // In depthwise mode in_idx tracks out_idx and in_lim equals out_lim,
    // so the same test marks the final item in both modes.
    assign w_is_last  = (r_out_idx == r_out_lim - c_ONE) && w_in_wrap;
    assign w_empty    = (r_out_lim == '0) || (r_in_lim == '0);
    assign w_div_done = w_div_o_done & w_div_i_done;

    scu_ceil_div #(
        .WIDTH   (IDX_WIDTH),
        .DIVISOR (POF)
    ) u_div_opr (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept),
        .clr      (abort),
        .dividend (out_ch),
        .done     (w_div_o_done),
        .quotient (w_opr)
    );

    scu_ceil_div #(
        .WIDTH   (IDX_WIDTH),
        .DIVISOR (PIF)
    ) u_div_ipc (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept),
        .clr      (abort),
        .dividend (mode_dw ? out_ch : in_ch),
        .done     (w_div_i_done),
        .quotient (w_ipc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = DIV;
            DIV:     if (w_div_done) w_state_nxt = w_empty ? DONE : RUN;
            RUN:     if (w_fire && w_is_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
        end
    end

    // Job configuration, band sizes and the item/band counters. The
    // counters move only on a transfer, so a stalled item holds stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_dw <= 1'b0;
            r_out_lim <= '0;
            r_in_lim  <= '0;
            r_opr     <= '0;
            r_ipc     <= '0;
            r_out_idx <= '0;
            r_in_idx  <= '0;
            r_o_sub   <= '0;
            r_i_sub   <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else if (abort) begin
            r_out_idx <= '0;
            r_in_idx  <= '0;
            r_o_sub   <= '0;
            r_i_sub   <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else if (w_accept) begin
            r_mode_dw <= mode_dw;
            r_out_lim <= out_ch;
            r_in_lim  <= mode_dw ? out_ch : in_ch;
            r_out_idx <= '0;
            r_in_idx  <= '0;
            r_o_sub   <= '0;
            r_i_sub   <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else if ((r_state == DIV) && w_div_done) begin
            r_opr <= w_opr;
            r_ipc <= w_ipc;
        end else if (w_fire && !w_is_last) begin
            // Input side: advance in depthwise mode and on a dense inner
            // step. Clear on a dense inner wrap.
            if (r_mode_dw || !w_in_wrap) begin
                r_in_idx <= r_in_idx + c_ONE;
                if (r_i_sub == r_ipc - c_ONE) begin
                    r_i_sub <= '0;
                    if (r_col != c_COL_MAX) r_col <= r_col + c_COL_ONE;
                end else begin
                    r_i_sub <= r_i_sub + c_ONE;
                end
            end else begin
                r_in_idx <= '0;
                r_i_sub  <= '0;
                r_col    <= '0;
            end
            // Output side: advance in depthwise mode and on a dense inner wrap.
            if (r_mode_dw || w_in_wrap) begin
                r_out_idx <= r_out_idx + c_ONE;
                if (r_o_sub == r_opr - c_ONE) begin
                    r_o_sub <= '0;
                    if (r_row != c_ROW_MAX) r_row <= r_row + c_ROW_ONE;
                end else begin
                    r_o_sub <= r_o_sub + c_ONE;
                end
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign m_valid   = (r_state == RUN);
    assign m_last    = (r_state == RUN) && w_is_last;
    assign m_out_idx = r_out_idx;
    assign m_in_idx  = r_in_idx;
    assign m_row     = r_row;
    assign m_col     = r_col;
    assign m_linear  = c_LIN_W'(r_row) * c_LIN_W'(PIF) + c_LIN_W'(r_col);

endmodule
`default_nettype wire
